mmio_hub: RTL

Parametrised successor to the fixed single-register MMIO block. It decodes a CPU data-memory window into a register file containing:
- an RX byte FIFO filled from the PDU UART path,
- a TX holding register with a valid/ack handshake to the PDU,
- an LED register of configurable width,
- a free-running timer with compare and sticky match flag.

It sits beside the memory bridge, and the top-level rdata mux selects its read data when the address hits the window.

---
 rtl/mmio_hub_if.sv | 34 +++
 rtl/mmio_hub.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mmio_hub_if.sv
// CPU data-memory bus and PDU UART signals of the MMIO hub.
// RX: pdu_uart_data_ready is held with a stable byte until a one-cycle
// pdu_uart_data_accept pulse; TX: cpu_uart_data_valid holds until cpu_uart_data_ack.
interface mmio_hub_if;
    logic [31:0] cpu_dmem_addr;
    logic        cpu_dmem_re;
    logic        cpu_dmem_we;
    logic [31:0] cpu_dmem_wdata;
    logic [31:0] cpu_dmem_rdata;
    logic        pdu_uart_data_ready;
    logic [7:0]  pdu_uart_data;
    logic        pdu_uart_data_accept;
    logic        cpu_uart_data_valid;
    logic [31:0] cpu_uart_data;
    logic        cpu_uart_data_ack;

    modport slave (
        input  cpu_dmem_addr, cpu_dmem_re, cpu_dmem_we, cpu_dmem_wdata,
        output cpu_dmem_rdata,
        input  pdu_uart_data_ready, pdu_uart_data,
        output pdu_uart_data_accept,
        output cpu_uart_data_valid, cpu_uart_data,
        input  cpu_uart_data_ack
    );

    modport master (
        output cpu_dmem_addr, cpu_dmem_re, cpu_dmem_we, cpu_dmem_wdata,
        input  cpu_dmem_rdata,
        output pdu_uart_data_ready, pdu_uart_data,
        input  pdu_uart_data_accept,
        input  cpu_uart_data_valid, cpu_uart_data,
        output cpu_uart_data_ack
    );
endinterface

// File: rtl/mmio_hub.sv
// MMIO register window: RX byte FIFO, TX holding register, LED register,
// and a free-running timer with compare and sticky match flag.
module mmio_hub #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          LED_W      = 8,
    parameter int          TIMER_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    mmio_hub_if.slave        bus,
    output logic [LED_W-1:0] led,
    output logic             irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_accept, r_stall, r_overrun;
    logic               r_tx_valid, r_tx_drop;
    logic [7:0]         r_tx_data;
    logic [LED_W-1:0]   r_led;
    logic [TIMER_W-1:0] r_timer, r_cmp;
    logic               r_timer_en, r_irq_en, r_flag;

    logic        w_hit, w_wr, w_rd;
    logic [2:0]  w_sel;
    logic        w_empty, w_full, w_push, w_stall, w_pop;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_hit   = (bus.cpu_dmem_addr[31:5] == BASE_ADDR[31:5]);
    assign w_sel   = bus.cpu_dmem_addr[4:2];
    assign w_wr    = bus.cpu_dmem_we & w_hit;
    assign w_rd    = bus.cpu_dmem_re & w_hit;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    // The !r_accept gate stops a held ready from pushing the same byte twice.
    assign w_push  = bus.pdu_uart_data_ready & ~r_accept & ~w_full;
    assign w_stall = bus.pdu_uart_data_ready & ~r_accept & w_full;
    assign w_pop   = w_rd && (w_sel == 3'd0) && !w_empty;
    assign w_unused = ^{bus.cpu_dmem_addr[1:0], bus.cpu_dmem_wdata};

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus.pdu_uart_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_accept  <= 1'b0;
            r_stall   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_accept <= w_push;
            r_stall  <= w_stall;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Only the first stalled cycle of a byte flags the overrun.
            if (w_stall && !r_stall)
                r_overrun <= 1'b1;
            else if (w_wr && w_sel == 3'd1)
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_valid <= 1'b0;
            r_tx_drop  <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (w_wr && w_sel == 3'd2) begin
                if (!r_tx_valid || bus.cpu_uart_data_ack) begin
                    r_tx_data  <= bus.cpu_dmem_wdata[7:0];
                    r_tx_valid <= 1'b1;
                end else begin
                    r_tx_drop <= 1'b1;
                end
            end else if (r_tx_valid && bus.cpu_uart_data_ack) begin
                r_tx_valid <= 1'b0;
            end
            if (w_wr && w_sel == 3'd3) r_tx_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led      <= '0;
            r_timer    <= '0;
            r_cmp      <= '1;
            r_timer_en <= 1'b0;
            r_irq_en   <= 1'b0;
            r_flag     <= 1'b0;
        end else begin
            if (w_wr && w_sel == 3'd4) r_led <= bus.cpu_dmem_wdata[LED_W-1:0];
            if (w_wr && w_sel == 3'd5)
                r_timer <= bus.cpu_dmem_wdata[TIMER_W-1:0];
            else if (r_timer_en)
                r_timer <= r_timer + TIMER_W'(1);
            if (w_wr && w_sel == 3'd6) r_cmp <= bus.cpu_dmem_wdata[TIMER_W-1:0];
            if (w_wr && w_sel == 3'd7) begin
                r_timer_en <= bus.cpu_dmem_wdata[0];
                r_irq_en   <= bus.cpu_dmem_wdata[1];
            end
            // A match on the same edge as a software clear keeps the flag set.
            if (r_timer_en && r_timer == r_cmp)
                r_flag <= 1'b1;
            else if (w_wr && w_sel == 3'd7 && bus.cpu_dmem_wdata[2])
                r_flag <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_sel)
                3'd0: if (!w_empty) w_rdata[7:0] = r_fifo[r_rd_ptr];
                3'd1: begin
                    w_rdata[0]    = ~w_empty;
                    w_rdata[1]    = w_full;
                    w_rdata[2]    = r_overrun;
                    w_rdata[15:8] = 8'(r_count);
                end
                3'd3: begin
                    w_rdata[0] = r_tx_valid;
                    w_rdata[1] = r_tx_drop;
                end
                3'd4: w_rdata[LED_W-1:0]   = r_led;
                3'd5: w_rdata[TIMER_W-1:0] = r_timer;
                3'd6: w_rdata[TIMER_W-1:0] = r_cmp;
                3'd7: w_rdata[2:0]         = {r_flag, r_irq_en, r_timer_en};
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.cpu_dmem_rdata       = w_rdata;
    assign bus.pdu_uart_data_accept = r_accept;
    assign bus.cpu_uart_data_valid  = r_tx_valid;
    assign bus.cpu_uart_data        = {24'b0, r_tx_data};
    assign led = r_led;
    assign irq = r_flag & r_irq_en;
endmodule
